bp_dma_arbiter: RTL and testbench
=================================

# bp_dma_arbiter

Round-robin arbiter that shares one bsg_cache DMA channel (packet, read-data and write-data streams) among `num_req_p` cache requesters. It sits between the per-cache DMA ports of a multicore BlackParrot unicore/L2 arrangement and the single `bsg_cache_to_axi` instance feeding the MIG AXI slave. Only one DMA transaction is outstanding at a time. The grant is held from packet issue through the final data beat of the block.

## Interface
Parameters:
- `num_req_p`, 2: number of requesting caches (≥1)
- `addr_width_p`, 28: DMA byte address width
- `data_width_p`, 64: DMA data beat width
- `block_size_in_words_p`, 8: beats per DMA transaction
- `pkt_width_lp` (local) = `addr_width_p+1`: packet `{write_not_read, addr}`; the MSB is `write_not_read`.

Ports:
- `clk_i`, in, 1: sole clock
- `reset_i`, in, 1: synchronous, active-high reset
- `dma_pkt_i`, in, `num_req_p*pkt_width_lp`: requester packets; requester i is at slice i
- `dma_pkt_v_i`, in, `num_req_p`: packet valid per requester
- `dma_pkt_yumi_o`, out, `num_req_p`: packet accepted
- `dma_data_o`, out, `data_width_p`: read data, broadcast to all requesters
- `dma_data_v_o`, out, `num_req_p`: read data valid, asserted to the granted requester only
- `dma_data_ready_i`, in, `num_req_p`: requester read-data ready
- `dma_data_i`, in, `num_req_p*data_width_p`: write data per requester
- `dma_data_v_i`, in, `num_req_p`: write data valid per requester
- `dma_data_yumi_o`, out, `num_req_p`: write data consumed
- `mem_dma_pkt_o`, out, `pkt_width_lp`: packet to the converter
- `mem_dma_pkt_v_o`, out, 1
- `mem_dma_pkt_yumi_i`, in, 1
- `mem_dma_data_i`, in, `data_width_p`: read data from the converter
- `mem_dma_data_v_i`, in, 1
- `mem_dma_data_ready_o`, out, 1
- `mem_dma_data_o`, out, `data_width_p`: write data to the converter
- `mem_dma_data_v_o`, out, 1
- `mem_dma_data_yumi_i`, in, 1
- `error_o`, out, 1: sticky protocol error (see Configuration)

## Operation
- FSM states:
  - `IDLE`: holds when no `dma_pkt_v_i` is asserted. If any is asserted, picks the first valid requester at or after `rr_ptr_r` (wrapping), registers it into `grant_r`, and goes to `ISSUE`.
  - `ISSUE`: drives `mem_dma_pkt_o` = packet of `grant_r` and `mem_dma_pkt_v_o`=1. Sets `dma_pkt_yumi_o[grant_r]` = `mem_dma_pkt_yumi_i`. On yumi, latches `write_not_read`, clears `beat_cnt_r`, and goes to `WRITE` if `write_not_read`=1, otherwise `READ`.
  - `READ`:
    - `mem_dma_data_ready_o` = `dma_data_ready_i[grant_r]`
    - `dma_data_v_o[grant_r]` = `mem_dma_data_v_i`
    - `dma_data_o` = `mem_dma_data_i`
    - a beat completes on v&ready
  - `WRITE`:
    - `mem_dma_data_o` = `dma_data_i[grant_r]`
    - `mem_dma_data_v_o` = `dma_data_v_i[grant_r]`
    - `dma_data_yumi_o[grant_r]` = `mem_dma_data_yumi_i`
    - a beat completes on yumi
- Each beat increments `beat_cnt_r`, which is `$clog2(block_size_in_words_p)` bits wide, min 1. On the beat where `beat_cnt_r == block_size_in_words_p-1`, go to `IDLE` and set `rr_ptr_r` = `grant_r+1` mod `num_req_p`.
- Non-granted requesters see all handshake outputs at 0 in every state.
- Requesters obey the bsg convention: `dma_pkt_v_i` stays high with a stable packet until yumi.
- A new requester raising `dma_pkt_v_i` mid-transaction waits. Round-robin guarantees service within `num_req_p` transactions.

## Timing
- Reset: state `IDLE`, `rr_ptr_r`=0, `grant_r`=0, `beat_cnt_r`=0, `error_o`=0. All outputs 0; data buses are don't-care but driven 0.
- Reset asserted mid-transaction aborts immediately to `IDLE` with no further handshakes. The converter is reset by the same `reset_i`.
- Arbitration latency: `pkt_v` seen in `IDLE` at cycle t gives `mem_dma_pkt_v_o` at t+1. The yumi pass-through is combinational in the same cycle.
- All data paths are combinational pass-through with no added latency, so full throughput is one beat per cycle.
- The minimum gap between transactions is one `IDLE` cycle.
- No combinational path from `mem_*_i` to `mem_*_o`.

## Configuration
- `BP_DMA_ARB_PROTOCOL_CHECK_EN` defined: `error_o` sets and stays set until reset on any of:
  - `dma_data_v_i[j]` high for j≠`grant_r`, or in a non-`WRITE` state
  - `dma_pkt_v_i[grant_r]` dropping while in `ISSUE`
  - `mem_dma_data_v_i` high outside `READ`
- In simulation each of these conditions also raises `$error`.
- Undefined: `error_o` is tied to 0 and the check logic is absent.

## Test plan
- Single read: req0 pkt `{0,0x100}`, converter returns 8 beats 0xA0..0xA7 → `dma_data_v_o`=01 for exactly 8 beats with matching data; `IDLE` reached after the beat count reaches 7.
- Single write: req1 pkt `{1,0x200}`, 8 data beats with random converter yumi stalls → `mem_dma_data_o` sequence identical; `dma_data_yumi_o`=10 only on accepted beats.
- Contention: both requesters valid at the same cycle from reset → req0 granted first, req1 second. Repeat with both always valid → grants alternate 0,1,0,1.
- Backpressure: `dma_data_ready_i[0]`=0 for 5 cycles mid-read → `mem_dma_data_ready_o`=0 for those cycles; no beat lost or duplicated.
- Reset at beat 3 of a write → next cycle all outputs 0 and `IDLE`; a fresh req0 read then completes normally.
- With `BP_DMA_ARB_PROTOCOL_CHECK_EN`: req1 asserts `dma_data_v_i` while req0 owns a read → `error_o`=1 next cycle and stays 1. Without the macro → `error_o`=0.

Source files
------------

// File: rtl/bp_dma_arbiter.sv
// Round-robin share of one bsg_cache DMA channel among num_req_p caches.
// Define BP_DMA_ARB_PROTOCOL_CHECK_EN to enable the sticky error_o check.
module bp_dma_arbiter #(
  parameter  int num_req_p             = 2,
  parameter  int addr_width_p          = 28,
  parameter  int data_width_p          = 64,
  parameter  int block_size_in_words_p = 8,
  localparam int pkt_width_lp          = addr_width_p + 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p*pkt_width_lp-1:0]    dma_pkt_i,
  input  logic [num_req_p-1:0]                 dma_pkt_v_i,
  output logic [num_req_p-1:0]                 dma_pkt_yumi_o,
  output logic [data_width_p-1:0]              dma_data_o,
  output logic [num_req_p-1:0]                 dma_data_v_o,
  input  logic [num_req_p-1:0]                 dma_data_ready_i,
  input  logic [num_req_p*data_width_p-1:0]    dma_data_i,
  input  logic [num_req_p-1:0]                 dma_data_v_i,
  output logic [num_req_p-1:0]                 dma_data_yumi_o,
  output logic [pkt_width_lp-1:0]              mem_dma_pkt_o,
  output logic                                 mem_dma_pkt_v_o,
  input  logic                                 mem_dma_pkt_yumi_i,
  input  logic [data_width_p-1:0]              mem_dma_data_i,
  input  logic                                 mem_dma_data_v_i,
  output logic                                 mem_dma_data_ready_o,
  output logic [data_width_p-1:0]              mem_dma_data_o,
  output logic                                 mem_dma_data_v_o,
  input  logic                                 mem_dma_data_yumi_i,
  output logic                                 error_o
);

  localparam int gw = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cw = (block_size_in_words_p > 1) ?
                      $clog2(block_size_in_words_p) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, READ, WRITE} state_e;

  state_e                  state_r;
  logic [gw-1:0]           grant_r;
  logic [gw-1:0]           rr_ptr_r;
  logic [gw-1:0]           pick;
  logic [gw-1:0]           next_ptr;
  logic [cw-1:0]           beat_cnt_r;
  logic [num_req_p-1:0]    gnt_oh;
  logic                    beat;
  logic                    last_beat;

  logic [pkt_width_lp-1:0] pkt_a [num_req_p];
  logic [data_width_p-1:0] wd_a  [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign pkt_a[g] = dma_pkt_i[g*pkt_width_lp +: pkt_width_lp];
    assign wd_a[g]  = dma_data_i[g*data_width_p +: data_width_p];
  end

  // Descending scan so the lowest offset from rr_ptr_r wins.
  always_comb begin
    pick = rr_ptr_r;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr_r) + k) % num_req_p;
      if (dma_pkt_v_i[idx]) pick = gw'(idx);
    end
  end

  always_comb begin
    gnt_oh          = '0;
    gnt_oh[grant_r] = 1'b1;
  end

  assign next_ptr  = (grant_r == gw'(num_req_p - 1)) ? '0 : grant_r + 1'b1;
  assign last_beat = (beat_cnt_r == cw'(block_size_in_words_p - 1));
  assign beat      = ((state_r == READ) && mem_dma_data_v_i
                      && dma_data_ready_i[grant_r])
                   || ((state_r == WRITE) && mem_dma_data_yumi_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      unique case (state_r)
        IDLE: if (|dma_pkt_v_i) begin
          grant_r <= pick;
          state_r <= ISSUE;
        end
        ISSUE: if (mem_dma_pkt_yumi_i) begin
          beat_cnt_r <= '0;
          state_r    <= pkt_a[grant_r][pkt_width_lp-1] ? WRITE : READ;
        end
        READ, WRITE: if (beat) begin
          beat_cnt_r <= beat_cnt_r + 1'b1;
          if (last_beat) begin
            state_r  <= IDLE;
            rr_ptr_r <= next_ptr;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  always_comb begin
    dma_pkt_yumi_o       = '0;
    dma_data_o           = '0;
    dma_data_v_o         = '0;
    dma_data_yumi_o      = '0;
    mem_dma_pkt_o        = '0;
    mem_dma_pkt_v_o      = 1'b0;
    mem_dma_data_ready_o = 1'b0;
    mem_dma_data_o       = '0;
    mem_dma_data_v_o     = 1'b0;
    unique case (state_r)
      ISSUE: begin
        mem_dma_pkt_o   = pkt_a[grant_r];
        mem_dma_pkt_v_o = 1'b1;
        dma_pkt_yumi_o  = gnt_oh & {num_req_p{mem_dma_pkt_yumi_i}};
      end
      READ: begin
        mem_dma_data_ready_o = dma_data_ready_i[grant_r];
        dma_data_v_o         = gnt_oh & {num_req_p{mem_dma_data_v_i}};
        dma_data_o           = mem_dma_data_i;
      end
      WRITE: begin
        mem_dma_data_o   = wd_a[grant_r];
        mem_dma_data_v_o = dma_data_v_i[grant_r];
        dma_data_yumi_o  = gnt_oh & {num_req_p{mem_dma_data_yumi_i}};
      end
      default: ;
    endcase
  end

`ifdef BP_DMA_ARB_PROTOCOL_CHECK_EN
  logic err_r;
  logic viol_data;
  logic viol_pkt;
  logic viol_mem;

  assign viol_data = |(dma_data_v_i & ((state_r == WRITE) ? ~gnt_oh : '1));
  assign viol_pkt  = (state_r == ISSUE) && !dma_pkt_v_i[grant_r];
  assign viol_mem  = mem_dma_data_v_i && (state_r != READ);

  always_ff @(posedge clk_i) begin
    if (reset_i) err_r <= 1'b0;
    else if (viol_data || viol_pkt || viol_mem) err_r <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (viol_data) $error("bp_dma_arbiter: stray write data valid");
      if (viol_pkt)  $error("bp_dma_arbiter: packet valid dropped");
      if (viol_mem)  $error("bp_dma_arbiter: read data outside READ");
    end
  end
`endif

  assign error_o = err_r;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_dma_arbiter.sv
// Self-checking bench for bp_dma_arbiter: directed scenarios plus
// random traffic compared every cycle against a transaction-level model.
module tb_bp_dma_arbiter;

  localparam int N  = 2;
  localparam int AW = 28;
  localparam int DW = 64;
  localparam int B  = 8;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [N*PW-1:0] dma_pkt_i;
  logic [N-1:0]  dma_pkt_v_i;
  logic [N-1:0]  dma_pkt_yumi_o;
  logic [DW-1:0] dma_data_o;
  logic [N-1:0]  dma_data_v_o;
  logic [N-1:0]  dma_data_ready_i;
  logic [N*DW-1:0] dma_data_i;
  logic [N-1:0]  dma_data_v_i;
  logic [N-1:0]  dma_data_yumi_o;
  logic [PW-1:0] mem_dma_pkt_o;
  logic          mem_dma_pkt_v_o;
  logic          mem_dma_pkt_yumi_i;
  logic [DW-1:0] mem_dma_data_i;
  logic          mem_dma_data_v_i;
  logic          mem_dma_data_ready_o;
  logic [DW-1:0] mem_dma_data_o;
  logic          mem_dma_data_v_o;
  logic          mem_dma_data_yumi_i;
  logic          error_o;

  logic [PW-1:0] pkt_q [N];
  logic [DW-1:0] wd_q  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign dma_pkt_i[g*PW +: PW]  = pkt_q[g];
    assign dma_data_i[g*DW +: DW] = wd_q[g];
  end

  always #5 clk = ~clk;

  bp_dma_arbiter #(
    .num_req_p(N), .addr_width_p(AW),
    .data_width_p(DW), .block_size_in_words_p(B)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i),
    .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
    .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i),
    .dma_data_yumi_o(dma_data_yumi_o),
    .mem_dma_pkt_o(mem_dma_pkt_o), .mem_dma_pkt_v_o(mem_dma_pkt_v_o),
    .mem_dma_pkt_yumi_i(mem_dma_pkt_yumi_i),
    .mem_dma_data_i(mem_dma_data_i), .mem_dma_data_v_i(mem_dma_data_v_i),
    .mem_dma_data_ready_o(mem_dma_data_ready_o),
    .mem_dma_data_o(mem_dma_data_o), .mem_dma_data_v_o(mem_dma_data_v_o),
    .mem_dma_data_yumi_i(mem_dma_data_yumi_i),
    .error_o(error_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 idle, 1 packet issue, 2 read block, 3 write block.
  int m_ph, m_own, m_ptr, m_beat;
  bit m_err;
  bit pend [N];
  int grants_q [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    dma_pkt_v_i = '0; dma_data_ready_i = '0; dma_data_v_i = '0;
    mem_dma_pkt_yumi_i = 1'b0; mem_dma_data_v_i = 1'b0;
    mem_dma_data_yumi_i = 1'b0; mem_dma_data_i = '0;
    for (int i = 0; i < N; i++) begin pkt_q[i] = '0; wd_q[i] = '0; end
  endtask

  task automatic model_check();
    logic [N-1:0]  e_py, e_dv, e_dy;
    logic [PW-1:0] e_pkt;
    logic          e_pv, e_rdy, e_mv;
    logic [DW-1:0] e_do, e_mdo;
    e_py = '0; e_dv = '0; e_dy = '0; e_pkt = '0;
    e_pv = 0; e_rdy = 0; e_mv = 0; e_do = '0; e_mdo = '0;
    case (m_ph)
      1: begin
        e_pv = 1; e_pkt = pkt_q[m_own];
        e_py[m_own] = mem_dma_pkt_yumi_i;
      end
      2: begin
        e_rdy = dma_data_ready_i[m_own];
        e_dv[m_own] = mem_dma_data_v_i;
        e_do = mem_dma_data_i;
      end
      3: begin
        e_mdo = wd_q[m_own];
        e_mv = dma_data_v_i[m_own];
        e_dy[m_own] = mem_dma_data_yumi_i;
      end
      default: ;
    endcase
    chk("m_pkt_yumi", dma_pkt_yumi_o, e_py);
    chk("m_pkt", mem_dma_pkt_o, e_pkt);
    chk("m_pkt_v", mem_dma_pkt_v_o, e_pv);
    chk("m_rd_v", dma_data_v_o, e_dv);
    chk("m_rd_data", dma_data_o, e_do);
    chk("m_rd_ready", mem_dma_data_ready_o, e_rdy);
    chk("m_wr_data", mem_dma_data_o, e_mdo);
    chk("m_wr_v", mem_dma_data_v_o, e_mv);
    chk("m_wr_yumi", dma_data_yumi_o, e_dy);
    chk("m_err", error_o, m_err);
  endtask

  // Called at negedge with inputs set; advances one clock.
  task automatic step();
    int  n_ph, n_own, n_ptr, n_beat;
    bit  n_err, bt, found;
    #1;
    if (!reset_i) begin
      model_check();
      for (int i = 0; i < N; i++)
        if (dma_pkt_yumi_o[i]) grants_q.push_back(i);
    end
    n_ph = m_ph; n_own = m_own; n_ptr = m_ptr; n_beat = m_beat;
    n_err = m_err; bt = 0; found = 0;
    if (reset_i) begin
      n_ph = 0; n_own = 0; n_ptr = 0; n_beat = 0; n_err = 0;
      for (int i = 0; i < N; i++) pend[i] = 0;
    end else begin
      case (m_ph)
        0: for (int k = 0; k < N; k++) begin
          if (!found && dma_pkt_v_i[(m_ptr + k) % N]) begin
            found = 1; n_own = (m_ptr + k) % N; n_ph = 1;
          end
        end
        1: if (mem_dma_pkt_yumi_i) begin
          n_ph = pkt_q[m_own][PW-1] ? 3 : 2;
          n_beat = 0; pend[m_own] = 0;
        end
        2: bt = mem_dma_data_v_i && dma_data_ready_i[m_own];
        3: bt = mem_dma_data_yumi_i;
        default: ;
      endcase
      if (bt) begin
        if (m_beat == B - 1) begin n_ph = 0; n_ptr = (m_own + 1) % N; end
        else n_beat = m_beat + 1;
      end
`ifdef BP_DMA_ARB_PROTOCOL_CHECK_EN
      for (int j = 0; j < N; j++)
        if (dma_data_v_i[j] && (m_ph != 3 || j != m_own)) n_err = 1;
      if (m_ph == 1 && !dma_pkt_v_i[m_own]) n_err = 1;
      if (mem_dma_data_v_i && m_ph != 2) n_err = 1;
`endif
    end
    @(posedge clk);
    m_ph = n_ph; m_own = n_own; m_ptr = n_ptr; m_beat = n_beat; m_err = n_err;
    @(negedge clk);
  endtask

  task automatic rand_inputs(input int p_req, input int p_conv);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(99) < p_req) begin
        pend[i] = 1;
        pkt_q[i] = {1'($urandom_range(1)), AW'($urandom)};
      end
      dma_pkt_v_i[i] = pend[i];
      dma_data_ready_i[i] = $urandom_range(99) < p_conv;
      wd_q[i] = {$urandom, $urandom};
    end
    dma_data_v_i = '0;
    if (m_ph == 3) dma_data_v_i[m_own] = $urandom_range(99) < p_conv;
    mem_dma_pkt_yumi_i = (m_ph == 1) && ($urandom_range(99) < p_conv);
    mem_dma_data_v_i = (m_ph == 2) && ($urandom_range(99) < p_conv);
    mem_dma_data_i = {$urandom, $urandom};
    mem_dma_data_yumi_i = (m_ph == 3) && dma_data_v_i[m_own]
                          && ($urandom_range(99) < p_conv);
  endtask

  task automatic do_read(input int r, input int addr, input logic [63:0] base,
                         input int stall_at, input int stall_len);
    int got, stalls, cyc;
    bit stalled;
    logic [N-1:0] oh;
    oh = '0; oh[r] = 1'b1;
    clear_in();
    dma_pkt_v_i[r] = 1; pkt_q[r] = {1'b0, AW'(addr)};
    step();
    mem_dma_pkt_yumi_i = 1;
    #1;
    chk("rd_pkt", mem_dma_pkt_o, {1'b0, AW'(addr)});
    chk("rd_pkt_yumi", dma_pkt_yumi_o, oh);
    step();
    clear_in();
    got = 0; stalls = 0; cyc = 0;
    while (got < B && cyc < 100) begin
      stalled = (got == stall_at) && (stalls < stall_len);
      mem_dma_data_v_i = 1; mem_dma_data_i = base + 64'(got);
      dma_data_ready_i[r] = !stalled;
      #1;
      if (stalled) chk("bp_ready", mem_dma_data_ready_o, 0);
      else begin
        chk("rd_v", dma_data_v_o, oh);
        chk("rd_data", dma_data_o, base + 64'(got));
      end
      step();
      if (stalled) stalls++; else got++;
      cyc++;
    end
    clear_in();
    chk("rd_beats", got, B);
    chk("rd_stalls", stalls, stall_len);
    dma_data_ready_i[r] = 1;
    #1;
    chk("rd_idle_rdy", mem_dma_data_ready_o, 0);
    chk("rd_idle_model", m_ph, 0);
    step();
    clear_in();
  endtask

  task automatic do_write(input int r, input int addr, input int stop_at);
    int k, cyc;
    bit y;
    logic [N-1:0] oh, ey;
    logic [63:0] d;
    oh = '0; oh[r] = 1'b1;
    clear_in();
    dma_pkt_v_i[r] = 1; pkt_q[r] = {1'b1, AW'(addr)};
    step();
    mem_dma_pkt_yumi_i = 1;
    #1;
    chk("wr_pkt", mem_dma_pkt_o, {1'b1, AW'(addr)});
    chk("wr_pkt_yumi", dma_pkt_yumi_o, oh);
    step();
    clear_in();
    k = 0; cyc = 0;
    while (k < stop_at && cyc < 200) begin
      y = ($urandom_range(2) != 0);
      d = 64'hDA7A_0000_0000_0000 | (64'(addr) << 8) | 64'(k);
      dma_data_v_i[r] = 1; wd_q[r] = d; mem_dma_data_yumi_i = y;
      ey = y ? oh : '0;
      #1;
      chk("wr_data", mem_dma_data_o, d);
      chk("wr_v", mem_dma_data_v_o, 1);
      chk("wr_yumi", dma_data_yumi_o, ey);
      step();
      if (y) k++;
      cyc++;
    end
    chk("wr_beats", k, stop_at);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int exp_g [4];
    exp_g = '{0, 1, 0, 1};
    m_ph = 0; m_own = 0; m_ptr = 0; m_beat = 0; m_err = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    clear_in();
    reset_i = 1;
    @(negedge clk);
    step(); step();
    #1;
    chk("rst_pkt_v", mem_dma_pkt_v_o, 0);
    chk("rst_pkt_yumi", dma_pkt_yumi_o, 0);
    chk("rst_rd_v", dma_data_v_o, 0);
    chk("rst_rdy", mem_dma_data_ready_o, 0);
    chk("rst_wr_v", mem_dma_data_v_o, 0);
    chk("rst_err", error_o, 0);
    step();
    reset_i = 0;

    do_read(0, 'h100, 64'hA0, -1, 0);
    do_write(1, 'h200, B);
    clear_in();
    #1;
    chk("wr_idle_model", m_ph, 0);
    chk("wr_idle_pkt_v", mem_dma_pkt_v_o, 0);
    step();

    do_read(0, 'h180, 64'hC0, 3, 5);

    do_write(0, 'h300, 3);
    clear_in();
    reset_i = 1;
    step();
    reset_i = 0;
    #1;
    chk("rst3_pkt_v", mem_dma_pkt_v_o, 0);
    chk("rst3_wr_v", mem_dma_data_v_o, 0);
    chk("rst3_wr_data", mem_dma_data_o, 0);
    chk("rst3_yumi", dma_data_yumi_o, 0);
    chk("rst3_model", m_ph, 0);
    step();
    do_read(0, 'h140, 64'hB0, -1, 0);

`ifdef BP_DMA_ARB_PROTOCOL_CHECK_EN
    clear_in();
    dma_pkt_v_i[0] = 1; pkt_q[0] = {1'b0, AW'('h120)};
    step();
    mem_dma_pkt_yumi_i = 1;
    step();
    clear_in();
    dma_data_v_i[1] = 1;
    step();
    clear_in();
    #1;
    chk("err_set", error_o, 1);
    step();
    #1;
    chk("err_sticky", error_o, 1);
    reset_i = 1;
    step();
    reset_i = 0;
    #1;
    chk("err_cleared", error_o, 0);
    step();
`else
    #1;
    chk("err_tied", error_o, 0);
    step();
`endif

    clear_in();
    reset_i = 1;
    step();
    reset_i = 0;
    grants_q.delete();
    cyc = 0;
    while (grants_q.size() < 4 && cyc < 200) begin
      rand_inputs(100, 100);
      step();
      cyc++;
    end
    chk("grants_n", grants_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (grants_q.size() > i) chk("grant_order", grants_q[i], exp_g[i]);

    for (int c = 0; c < 3000; c++) begin
      rand_inputs(30, 60);
      reset_i = ($urandom_range(499) == 0);
      step();
      reset_i = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
